// File: rtl/ext_rst_req_gen.sv
// Fabric reset requester: merges software, watchdog and PLL-lock-loss sources into one timed
// active-low EXT_RST_N pulse, then tracks the reset core's FABRIC_RESET_N assert/release handshake.
module ext_rst_req_gen #(
  parameter int unsigned PULSE_CYCLES   = 16,
  parameter int unsigned ACK_TIMEOUT    = 1024,
  parameter int unsigned HOLDOFF_CYCLES = 256,
  parameter int unsigned WDT_W          = 24
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SW_RST_REQ,
  input  logic             WDT_EN,
  input  logic             WDT_KICK,
  input  logic [WDT_W-1:0] WDT_TIMEOUT,
  input  logic             PLL_LOCK,
  input  logic             LOCK_LOSS_EN,
  input  logic             FABRIC_RESET_N,
  input  logic             CAUSE_CLR,
  output logic             EXT_RST_N,
  output logic             BUSY,
  output logic [2:0]       CAUSE,
  output logic             ACK_ERR,
  output logic [7:0]       RST_COUNT
);

  localparam int unsigned TMR_MAX_A = (PULSE_CYCLES > ACK_TIMEOUT) ? PULSE_CYCLES : ACK_TIMEOUT;
  localparam int unsigned TMR_MAX   = (TMR_MAX_A > HOLDOFF_CYCLES) ? TMR_MAX_A : HOLDOFF_CYCLES;
  localparam int unsigned TMR_W     = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] PULSE_LAST   = TMR_W'(PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] ACK_LAST     = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] HOLDOFF_LAST = TMR_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSERT,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_HOLDOFF
  } state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [WDT_W-1:0]   wdt_cnt_q, wdt_cnt_d;
  logic               ext_rst_n_q, ext_rst_n_d;
  logic               busy_q, busy_d;
  logic [2:0]         cause_q, cause_d;
  logic               ack_err_q, ack_err_d;
  logic [7:0]         rst_count_q, rst_count_d;
  logic               pending_q, pending_d;
  logic               acked_q, acked_d;
  logic               pll_lock_q;

  logic               wdt_active;
  logic               wdt_fire;
  logic               lock_req;
  logic [2:0]         req_vec;
  logic               any_req;
  logic               ack_err_set;
  logic               count_inc;

  // Request sources, evaluated every cycle regardless of state.
  assign wdt_active = WDT_EN && (WDT_TIMEOUT != '0) && (state_q == S_IDLE);
  assign wdt_fire   = wdt_active && !WDT_KICK && (wdt_cnt_q == WDT_TIMEOUT - WDT_W'(1));
  assign lock_req   = pll_lock_q && !PLL_LOCK && LOCK_LOSS_EN && FABRIC_RESET_N;
  assign req_vec    = {lock_req, wdt_fire, SW_RST_REQ};
  assign any_req    = |req_vec;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d     = state_q;
    tmr_d       = tmr_q + TMR_W'(1);
    ext_rst_n_d = 1'b1;
    pending_d   = pending_q;
    acked_d     = acked_q;
    ack_err_set = 1'b0;
    count_inc   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (any_req || pending_q) begin
          state_d     = S_ASSERT;
          ext_rst_n_d = 1'b0;
          pending_d   = 1'b0;
          acked_d     = 1'b0;
        end
      end
      S_ASSERT: begin
        ext_rst_n_d = 1'b0;
        if (!FABRIC_RESET_N) acked_d = 1'b1;
        if (tmr_q == PULSE_LAST) begin
          ext_rst_n_d = 1'b1;
          tmr_d       = '0;
          state_d     = (acked_q || !FABRIC_RESET_N) ? S_WAIT_HIGH : S_WAIT_LOW;
        end
      end
      S_WAIT_LOW: begin
        if (!FABRIC_RESET_N) begin
          tmr_d   = '0;
          state_d = S_WAIT_HIGH;
        end else if (tmr_q == ACK_LAST) begin
          ack_err_set = 1'b1;
          count_inc   = 1'b1;
          tmr_d       = '0;
          state_d     = S_HOLDOFF;
        end
      end
      S_WAIT_HIGH: begin
        if (FABRIC_RESET_N || (tmr_q == ACK_LAST)) begin
          ack_err_set = !FABRIC_RESET_N;
          count_inc   = 1'b1;
          tmr_d       = '0;
          state_d     = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        // Requests arriving while the core settles collapse into one deferred sequence.
        if (any_req) pending_d = 1'b1;
        if (tmr_q == HOLDOFF_LAST) begin
          tmr_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        tmr_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);

    wdt_cnt_d = (wdt_active && !WDT_KICK && !wdt_fire) ? wdt_cnt_q + WDT_W'(1) : '0;

    // A request in the same cycle as CAUSE_CLR still leaves its bit set.
    cause_d   = (CAUSE_CLR ? 3'b000 : cause_q) | req_vec;
    ack_err_d = (ack_err_q && !CAUSE_CLR) || ack_err_set;

    rst_count_d = (count_inc && (rst_count_q != 8'hFF)) ? rst_count_q + 8'd1 : rst_count_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      wdt_cnt_q   <= '0;
      ext_rst_n_q <= 1'b1;
      busy_q      <= 1'b0;
      cause_q     <= 3'b000;
      ack_err_q   <= 1'b0;
      rst_count_q <= 8'd0;
      pending_q   <= 1'b0;
      acked_q     <= 1'b0;
      pll_lock_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      wdt_cnt_q   <= wdt_cnt_d;
      ext_rst_n_q <= ext_rst_n_d;
      busy_q      <= busy_d;
      cause_q     <= cause_d;
      ack_err_q   <= ack_err_d;
      rst_count_q <= rst_count_d;
      pending_q   <= pending_d;
      acked_q     <= acked_d;
      pll_lock_q  <= PLL_LOCK;
    end
  end

  assign EXT_RST_N = ext_rst_n_q;
  assign BUSY      = busy_q;
  assign CAUSE     = cause_q;
  assign ACK_ERR   = ack_err_q;
  assign RST_COUNT = rst_count_q;

endmodule

// File: tb/tb_ext_rst_req_gen.sv
// Bench for ext_rst_req_gen: a model reset core answers EXT_RST_N pulses, a scoreboard checks
// each pulse's length and logged cause, and a small-parameter instance exercises count saturation.
module tb_ext_rst_req_gen;

  localparam int PULSE = 16;

  logic        clk;
  logic        rst;
  logic        sw_rst_req;
  logic        wdt_en;
  logic        wdt_kick;
  logic [23:0] wdt_timeout;
  logic        pll_lock;
  logic        lock_loss_en;
  logic        frn;
  logic        cause_clr;
  logic        ext_rst_n;
  logic        busy;
  logic [2:0]  cause;
  logic        ack_err;
  logic [7:0]  rst_count;

  logic        s_sw;
  logic        s_ext_rst_n;
  logic        s_busy;
  logic [2:0]  s_cause;
  logic        s_ack_err;
  logic [7:0]  s_count;

  int n_pass  = 0;
  int n_total = 0;
  bit core_en = 1'b0;

  typedef struct {
    int       len;
    logic [2:0] cause;
  } pulse_t;

  pulse_t sb_q[$];
  pulse_t exp_p;
  int     low_run = 0;

  ext_rst_req_gen u_dut (
    .CLK(clk), .RST(rst), .SW_RST_REQ(sw_rst_req), .WDT_EN(wdt_en), .WDT_KICK(wdt_kick),
    .WDT_TIMEOUT(wdt_timeout), .PLL_LOCK(pll_lock), .LOCK_LOSS_EN(lock_loss_en),
    .FABRIC_RESET_N(frn), .CAUSE_CLR(cause_clr), .EXT_RST_N(ext_rst_n), .BUSY(busy),
    .CAUSE(cause), .ACK_ERR(ack_err), .RST_COUNT(rst_count)
  );

  // Short-parameter instance whose core never answers, so each sequence ends by timeout quickly.
  ext_rst_req_gen #(.PULSE_CYCLES(2), .ACK_TIMEOUT(8), .HOLDOFF_CYCLES(4), .WDT_W(8)) u_sat (
    .CLK(clk), .RST(rst), .SW_RST_REQ(s_sw), .WDT_EN(1'b0), .WDT_KICK(1'b0),
    .WDT_TIMEOUT(8'd0), .PLL_LOCK(1'b1), .LOCK_LOSS_EN(1'b0),
    .FABRIC_RESET_N(1'b1), .CAUSE_CLR(1'b0), .EXT_RST_N(s_ext_rst_n), .BUSY(s_busy),
    .CAUSE(s_cause), .ACK_ERR(s_ack_err), .RST_COUNT(s_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic pulse_t mk_pulse(input int len, input logic [2:0] c);
    pulse_t p;
    p.len   = len;
    p.cause = c;
    return p;
  endfunction

  // Model reset core: asserts FABRIC_RESET_N 3 cycles after EXT_RST_N falls, holds it 40 cycles.
  initial begin
    frn = 1'b1;
    forever begin
      @(negedge clk);
      if (core_en && ext_rst_n === 1'b0) begin
        repeat (3) @(posedge clk);
        #1 frn = 1'b0;
        repeat (40) @(posedge clk);
        #1 frn = 1'b1;
        while (ext_rst_n !== 1'b1) @(negedge clk);
      end
    end
  end

  // Pulse monitor: each completed low run is popped against the expected pulse.
  always @(negedge clk) begin
    if (ext_rst_n === 1'b0) begin
      low_run++;
    end else if (low_run != 0) begin
      n_total++;
      if (sb_q.size() == 0) begin
        $display("FAIL pulse_unexpected: got low run %0d cause %b, want no pulse", low_run, cause);
      end else begin
        exp_p = sb_q.pop_front();
        if (low_run !== exp_p.len || cause !== exp_p.cause)
          $display("FAIL pulse: got len %0d cause %b, want len %0d cause %b",
                   low_run, cause, exp_p.len, exp_p.cause);
        else
          n_pass++;
      end
      low_run = 0;
    end
  end

  task automatic do_reset();
    sw_rst_req   = 1'b0;
    wdt_en       = 1'b0;
    wdt_kick     = 1'b0;
    wdt_timeout  = '0;
    pll_lock     = 1'b1;
    lock_loss_en = 1'b0;
    cause_clr    = 1'b0;
    s_sw         = 1'b0;
    rst          = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic sw_pulse();
    @(posedge clk); #1 sw_rst_req = 1'b1;
    @(posedge clk); #1 sw_rst_req = 1'b0;
  endtask

  task automatic wait_ext(input logic lvl, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ext_rst_n === lvl) begin ok = 1'b1; return; end
    end
  endtask

  task automatic wait_frn(input logic lvl, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frn === lvl) begin ok = 1'b1; return; end
    end
  endtask

  task automatic wait_busy_low(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1'b1; return; end
    end
  endtask

  task automatic test_reset();
    bit saw_low;
    do_reset();
    @(negedge clk);
    n_total++; if (ext_rst_n !== 1'b1) $display("FAIL reset_ext: got %b want 1", ext_rst_n); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (cause !== 3'b000) $display("FAIL reset_cause: got %b want 000", cause); else n_pass++;
    n_total++; if (ack_err !== 1'b0) $display("FAIL reset_ackerr: got %b want 0", ack_err); else n_pass++;
    n_total++; if (rst_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", rst_count); else n_pass++;
    saw_low = 1'b0;
    repeat (20) begin @(negedge clk); if (ext_rst_n !== 1'b1) saw_low = 1'b1; end
    n_total++; if (saw_low) $display("FAIL reset_quiet: got pulse want none"); else n_pass++;
  endtask

  task automatic test_sw_pulse();
    bit ok;
    int hold;
    do_reset();
    core_en = 1'b1;
    sb_q.push_back(mk_pulse(PULSE, 3'b001));
    sw_pulse();
    wait_frn(1'b0, 100, ok);
    n_total++; if (!ok) $display("FAIL sw_core_low: got timeout want ack"); else n_pass++;
    wait_frn(1'b1, 100, ok);
    n_total++; if (!ok) $display("FAIL sw_core_high: got timeout want release"); else n_pass++;
    hold = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy === 1'b1) hold++; else break;
    end
    n_total++; if (hold !== 256) $display("FAIL sw_holdoff: got %0d want 256", hold); else n_pass++;
    n_total++; if (cause !== 3'b001) $display("FAIL sw_cause: got %b want 001", cause); else n_pass++;
    n_total++; if (rst_count !== 8'd1) $display("FAIL sw_count: got %0d want 1", rst_count); else n_pass++;
    n_total++; if (ack_err !== 1'b0) $display("FAIL sw_ackerr: got %b want 0", ack_err); else n_pass++;
    n_total++; if (sb_q.size() != 0) $display("FAIL sw_sb: got %0d pending want 0", sb_q.size()); else n_pass++;
  endtask

  task automatic test_watchdog();
    bit ok, fell, saw_low;
    int n;
    do_reset();
    core_en = 1'b1;
    @(posedge clk); #1;
    wdt_timeout = 24'd100;
    wdt_en      = 1'b1;
    sb_q.push_back(mk_pulse(PULSE, 3'b010));
    n = 1;
    fell = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ext_rst_n === 1'b0) begin fell = 1'b1; break; end
      @(posedge clk);
      n++;
    end
    n_total++; if (!fell || n != 101) $display("FAIL wdt_fall_cycle: got %0d want 101", n); else n_pass++;
    @(posedge clk); #1 wdt_en = 1'b0;
    wait_busy_low(600, ok);
    n_total++; if (!ok) $display("FAIL wdt_done: got timeout want idle"); else n_pass++;
    n_total++; if (cause !== 3'b010) $display("FAIL wdt_cause: got %b want 010", cause); else n_pass++;
    n_total++; if (sb_q.size() != 0) $display("FAIL wdt_sb: got %0d pending want 0", sb_q.size()); else n_pass++;

    do_reset();
    wdt_timeout = 24'd100;
    wdt_en      = 1'b1;
    saw_low     = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1 wdt_kick = (c % 50 == 49);
      @(negedge clk); if (ext_rst_n !== 1'b1) saw_low = 1'b1;
    end
    wdt_kick = 1'b0;
    n_total++; if (saw_low || cause !== 3'b000) $display("FAIL wdt_kicked: got low=%b cause %b want 0 000", saw_low, cause); else n_pass++;

    wdt_timeout = 24'd0;
    saw_low     = 1'b0;
    repeat (150) begin @(negedge clk); if (ext_rst_n !== 1'b1) saw_low = 1'b1; end
    wdt_en = 1'b0;
    n_total++; if (saw_low) $display("FAIL wdt_zero_timeout: got pulse want none"); else n_pass++;
  endtask

  task automatic test_lock_loss();
    bit ok, saw_low;
    do_reset();
    core_en = 1'b1;
    @(posedge clk); #1 lock_loss_en = 1'b1;
    @(posedge clk); #1;
    pll_lock   = 1'b0;
    sw_rst_req = 1'b1;
    sb_q.push_back(mk_pulse(PULSE, 3'b101));
    @(posedge clk); #1 sw_rst_req = 1'b0;
    wait_ext(1'b0, 10, ok);
    wait_busy_low(600, ok);
    n_total++; if (!ok) $display("FAIL lock_done: got timeout want idle"); else n_pass++;
    n_total++; if (cause !== 3'b101) $display("FAIL lock_cause: got %b want 101", cause); else n_pass++;
    n_total++; if (rst_count !== 8'd1) $display("FAIL lock_count: got %0d want 1", rst_count); else n_pass++;
    n_total++; if (sb_q.size() != 0) $display("FAIL lock_sb: got %0d pending want 0", sb_q.size()); else n_pass++;

    do_reset();
    @(posedge clk); #1;
    @(posedge clk); #1 pll_lock = 1'b0;
    saw_low = 1'b0;
    repeat (30) begin @(negedge clk); if (ext_rst_n !== 1'b1) saw_low = 1'b1; end
    n_total++; if (saw_low || cause !== 3'b000) $display("FAIL lock_disabled: got low=%b cause %b want 0 000", saw_low, cause); else n_pass++;
  endtask

  task automatic test_ack_timeout();
    bit ok;
    int clean;
    do_reset();
    core_en = 1'b0;
    sb_q.push_back(mk_pulse(PULSE, 3'b001));
    sw_pulse();
    wait_ext(1'b0, 10, ok);
    clean = 0;
    for (int i = 0; i < 2000; i++) begin
      if (ack_err !== 1'b0) break;
      clean++;
      @(negedge clk);
    end
    n_total++; if (clean != PULSE + 1024) $display("FAIL ack_timeout_len: got %0d want %0d", clean, PULSE + 1024); else n_pass++;
    n_total++; if (rst_count !== 8'd1) $display("FAIL ack_count: got %0d want 1", rst_count); else n_pass++;
    wait_busy_low(300, ok);
    n_total++; if (!ok) $display("FAIL ack_idle: got timeout want idle after holdoff"); else n_pass++;

    @(posedge clk); #1;
    cause_clr  = 1'b1;
    sw_rst_req = 1'b1;
    sb_q.push_back(mk_pulse(PULSE, 3'b001));
    @(posedge clk); #1;
    cause_clr  = 1'b0;
    sw_rst_req = 1'b0;
    @(negedge clk);
    n_total++; if (cause !== 3'b001 || ack_err !== 1'b0) $display("FAIL clr_vs_req: got cause %b err %b want 001 0", cause, ack_err); else n_pass++;
    wait_busy_low(1500, ok);
    n_total++; if (rst_count !== 8'd2 || ack_err !== 1'b1) $display("FAIL ack_second: got count %0d err %b want 2 1", rst_count, ack_err); else n_pass++;
    @(posedge clk); #1 cause_clr = 1'b1;
    @(posedge clk); #1 cause_clr = 1'b0;
    @(negedge clk);
    n_total++; if (cause !== 3'b000 || ack_err !== 1'b0) $display("FAIL cause_clr: got cause %b err %b want 000 0", cause, ack_err); else n_pass++;
    n_total++; if (sb_q.size() != 0) $display("FAIL ack_sb: got %0d pending want 0", sb_q.size()); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    core_en = 1'b1;
    sb_q.push_back(mk_pulse(PULSE, 3'b001));
    sw_pulse();
    wait_ext(1'b0, 10, ok);
    wait_ext(1'b1, 40, ok);
    sw_pulse();
    wait_frn(1'b1, 100, ok);
    n_total++; if (!ok) $display("FAIL b2b_release: got timeout want release"); else n_pass++;
    repeat (10) @(posedge clk);
    sw_pulse();
    repeat (20) @(posedge clk);
    sw_pulse();
    sb_q.push_back(mk_pulse(PULSE, 3'b001));
    wait_ext(1'b0, 400, ok);
    n_total++; if (!ok) $display("FAIL b2b_deferred: got no pulse want one"); else n_pass++;
    wait_busy_low(600, ok);
    n_total++; if (rst_count !== 8'd2) $display("FAIL b2b_count: got %0d want 2", rst_count); else n_pass++;
    repeat (300) @(negedge clk);
    n_total++; if (busy !== 1'b0 || sb_q.size() != 0) $display("FAIL b2b_single: got busy %b pending %0d want 0 0", busy, sb_q.size()); else n_pass++;
  endtask

  task automatic test_mid_reset();
    bit saw_low;
    core_en = 1'b0;
    // Pulse is cut after 6 low cycles by RST, with CAUSE already cleared at the release sample.
    sb_q.push_back(mk_pulse(6, 3'b000));
    sw_pulse();
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_total++; if (ext_rst_n !== 1'b1) $display("FAIL midrst_ext: got %b want 1", ext_rst_n); else n_pass++;
    n_total++; if (cause !== 3'b000) $display("FAIL midrst_cause: got %b want 000", cause); else n_pass++;
    n_total++; if (rst_count !== 8'd0) $display("FAIL midrst_count: got %0d want 0", rst_count); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
    saw_low = 1'b0;
    repeat (20) begin @(negedge clk); if (ext_rst_n !== 1'b1) saw_low = 1'b1; end
    n_total++; if (saw_low || sb_q.size() != 0) $display("FAIL midrst_quiet: got low=%b pending %0d want 0 0", saw_low, sb_q.size()); else n_pass++;
  endtask

  task automatic test_saturation();
    int low, stuck;
    bit done;
    do_reset();
    stuck = 0;
    for (int s = 1; s <= 256; s++) begin
      @(posedge clk); #1 s_sw = 1'b1;
      @(posedge clk); #1 s_sw = 1'b0;
      low  = 0;
      done = 1'b0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (s_ext_rst_n === 1'b0) low++;
        if (s_busy === 1'b0) begin done = 1'b1; break; end
      end
      if (!done) stuck++;
      if (s == 1) begin
        n_total++; if (low != 2) $display("FAIL sat_min_pulse: got %0d want 2", low); else n_pass++;
      end
      if (s == 255) begin
        n_total++; if (s_count !== 8'd255) $display("FAIL sat_255: got %0d want 255", s_count); else n_pass++;
      end
    end
    n_total++; if (stuck != 0) $display("FAIL sat_done: got %0d stuck sequences want 0", stuck); else n_pass++;
    n_total++; if (s_count !== 8'd255) $display("FAIL sat_hold: got %0d want 255", s_count); else n_pass++;
    n_total++; if (s_ack_err !== 1'b1 || s_cause !== 3'b001) $display("FAIL sat_flags: got err %b cause %b want 1 001", s_ack_err, s_cause); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_sw_pulse();
    test_watchdog();
    test_lock_loss();
    test_ack_timeout();
    test_back_to_back();
    test_mid_reset();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
